// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural bin order out.
// Ports: clk, rst, in_valid/in_ready/in_re/in_im, out_valid/out_ready/out_re/out_im/out_idx
//   (+ out_last and debug frame_cnt_q when FFT_REORDER_LAST_EN is defined).
module fft_bitrev_reorder #(
  parameter int WIDTH = 32,
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [LOG2N-1:0] out_idx
`ifdef FFT_REORDER_LAST_EN
  ,
  output logic             out_last
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_e;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] v
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  bank_st_e         st_q [2];
  bank_st_e         st_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       full;
  logic             wr_fire, rd_fire;
  logic             wr_last, rd_last;

  logic [WIDTH-1:0] mem_re [2*N];
  logic [WIDTH-1:0] mem_im [2*N];

  // A bank counts as full from its Nth write until its Nth read.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      full[b] = (st_q[b] == FULL) || (st_q[b] == DRAINING);
    end
  end

  assign in_ready  = !full[wr_bank_q];
  assign out_valid = full[rd_bank_q];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign wr_last   = (wr_cnt_q == LOG2N'(N-1));
  assign rd_last   = (rd_cnt_q == LOG2N'(N-1));

  assign out_re  = mem_re[{rd_bank_q, rd_cnt_q}];
  assign out_im  = mem_im[{rd_bank_q, rd_cnt_q}];
  assign out_idx = rd_cnt_q;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_last) rd_bank_d = ~rd_bank_q;
    end
    // Write needs !full and read needs full, so a bank never sees both.
    for (int b = 0; b < 2; b++) begin
      unique case (st_q[b])
        EMPTY: begin
          if (wr_fire && wr_bank_q == 1'(b))
            st_d[b] = FILLING;
        end
        FILLING: begin
          if (wr_fire && wr_bank_q == 1'(b) && wr_last)
            st_d[b] = FULL;
        end
        FULL: begin
          if (rd_fire && rd_bank_q == 1'(b))
            st_d[b] = DRAINING;
        end
        DRAINING: begin
          if (rd_fire && rd_bank_q == 1'(b) && rd_last)
            st_d[b] = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
    end
  end

  // Storage is not reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re[{wr_bank_q, bitrev(wr_cnt_q)}] <= in_re;
      mem_im[{wr_bank_q, bitrev(wr_cnt_q)}] <= in_im;
    end
  end

`ifdef FFT_REORDER_LAST_EN
  logic [15:0] frame_cnt_q;

  assign out_last = out_valid & rd_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (rd_fire && rd_last) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder against a frame-level
// bit-reverse scoreboard.
module tb_fft_bitrev_reorder;

  localparam int W  = 32;
  localparam int N  = 64;
  localparam int LG = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_re;
  logic [W-1:0]  in_im;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_re;
  logic [W-1:0]  out_im;
  logic [LG-1:0] out_idx;
`ifdef FFT_REORDER_LAST_EN
  logic          out_last;
`endif

  fft_bitrev_reorder #(
    .WIDTH(W),
    .N(N),
    .LOG2N(LG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_re(in_re),
    .in_im(in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re(out_re),
    .out_im(out_im),
    .out_idx(out_idx)
`ifdef FFT_REORDER_LAST_EN
    ,
    .out_last(out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: frames collected in arrival order, then published
  // in natural order (output n = input sample number bitrev(n)).
  logic [63:0] cur_q [$];
  logic [63:0] exp_q [$];
  int          m_full;
  int          m_rd;
  int          acc;

  function automatic int brev(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < LG; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    m_full = 0;
    m_rd   = 0;
    acc    = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_idx", {58'd0, out_idx}, 64'd0);
`ifdef FFT_REORDER_LAST_EN
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, check at negedge, then advance the model.
  task automatic cyc(input logic iv, input logic [W-1:0] re,
                     input logic [W-1:0] im, input logic ordy);
    bit wf;
    bit rf;
    in_valid  = iv;
    in_re     = re;
    in_im     = im;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_full < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_full > 0});
    if (m_full > 0) begin
      chk("out_re", {32'd0, out_re}, {32'd0, exp_q[0][63:32]});
      chk("out_im", {32'd0, out_im}, {32'd0, exp_q[0][31:0]});
      chk("out_idx", {58'd0, out_idx}, 64'(m_rd));
    end
`ifdef FFT_REORDER_LAST_EN
    chk("out_last", {63'd0, out_last},
        {63'd0, (m_full > 0) && (m_rd == N-1)});
`endif
    wf = iv && (m_full < 2);
    rf = (m_full > 0) && ordy;
    @(posedge clk);
    #1;
    if (rf) begin
      void'(exp_q.pop_front());
      m_rd++;
      if (m_rd == N) begin
        m_rd = 0;
        m_full--;
      end
    end
    if (wf) begin
      acc++;
      cur_q.push_back({re, im});
      if (cur_q.size() == N) begin
        for (int n = 0; n < N; n++) exp_q.push_back(cur_q[brev(n)]);
        cur_q.delete();
        m_full++;
      end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 4*N && m_full > 0; c++) cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);

    // 1: ramp frame, in_re=k, in_im=-k
    do_reset();
    for (int k = 0; k < N; k++) cyc(1'b1, W'(k), W'(-k), 1'b1);
    drain();

    // 2: four back-to-back frames, value 100*f+k
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++)
        cyc(1'b1, W'(100*f + k), W'(-(100*f + k)), 1'b1);
    drain();
`ifdef FFT_REORDER_LAST_EN
    chk("frame_cnt", {48'd0, dut.frame_cnt_q}, 64'd4);
`endif

    // 3: sink stalled while three frames are offered
    do_reset();
    for (int c = 0; c < 2*N + 20; c++) cyc(1'b1, $urandom, $urandom, 1'b0);
    for (int c = 0; c < 1000 && acc < 3*N; c++)
      cyc(1'b1, $urandom, $urandom, 1'b1);
    drain();

    // 4: toggling out_ready, random in_valid
    do_reset();
    for (int c = 0; c < 3000 && acc < 3*N; c++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'(c % 2));
    drain();

    // 5: reset after 20 writes, then one clean frame
    do_reset();
    for (int k = 0; k < 20; k++) cyc(1'b1, $urandom, $urandom, 1'b1);
    do_reset();
    for (int k = 0; k < N; k++) cyc(1'b1, W'(5000 + k), $urandom, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
